fila_cmd: RTL and testbench

- Command front-end directly upstream of the 8-entry queue.
- Turns two raw push buttons and an 8-bit switch bank into clean single-cycle enqueue/dequeue strobes and a stable data word.
- Guards against overflow and underflow using the queue's reported length.
- Enforces a hold-off so the queue's two-cycle dequeue and one-cycle-late length update always complete before the next command.

---
 rtl/fila_pkg.sv | 13 +
 rtl/fila_debounce.sv | 54 +++++
 rtl/fila_cmd.sv | 121 ++++++++++++
 tb/tb_fila_cmd.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fila_pkg.sv
// Shared types and defaults for the fila command front-end.
package fila_pkg;
  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 8;
  localparam int MIN_HOLDOFF = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE_ENQ = 2'd1,
    ISSUE_DEQ = 2'd2,
    HOLD      = 2'd3
  } cmd_state_t;
endpackage

// File: rtl/fila_debounce.sv
// Two-flop synchronizer plus counting debouncer; emits a one-cycle pulse on a
// debounced rising level.
module fila_debounce #(
  parameter int DEBOUNCE_CYCLES = 200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronized level disagrees with the
  // accepted level; reaching the threshold flips the accepted level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
      rise_d   = ~stable_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
endmodule

// File: rtl/fila_cmd.sv
// Queue command front-end: debounced buttons -> guarded single-cycle
// enqueue/dequeue strobes with a post-command hold-off.
module fila_cmd
  import fila_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEPTH           = DEPTH_DEF,
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int HOLDOFF         = 3
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic              btn_enq,
  input  logic              btn_deq,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [DATA_W-1:0] len_in,
  output logic [DATA_W-1:0] data_out,
  output logic              enqueue_out,
  output logic              dequeue_out,
  output logic              busy,
  output logic              err_full,
  output logic              err_empty
);
  localparam int HOLD_EFF = (HOLDOFF < MIN_HOLDOFF) ? MIN_HOLDOFF : HOLDOFF;
  localparam int HW       = $clog2(HOLD_EFF + 1);

  logic enq_rise, deq_rise;
  logic enq_lvl, deq_lvl;

  fila_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enq (
    .clk_i(clk_10KHz), .rst_i(reset), .btn_i(btn_enq),
    .level_o(enq_lvl), .rise_o(enq_rise)
  );

  fila_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_deq (
    .clk_i(clk_10KHz), .rst_i(reset), .btn_i(btn_deq),
    .level_o(deq_lvl), .rise_o(deq_rise)
  );

  cmd_state_t        state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              enq_pend_q, enq_pend_d;
  logic              deq_pend_q, deq_pend_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_full_q, err_full_d;
  logic              err_empty_q, err_empty_d;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    enq_pend_d  = enq_pend_q | enq_rise;
    deq_pend_d  = deq_pend_q | deq_rise;
    data_d      = data_q;
    err_full_d  = err_full_q;
    err_empty_d = err_empty_q;
    case (state_q)
      IDLE: begin
        if (enq_pend_q) begin
          enq_pend_d = 1'b0;
          hold_d     = '0;
          if (len_in >= DATA_W'(DEPTH)) begin
            err_full_d = 1'b1;
            state_d    = HOLD;
          end else begin
            data_d  = sw_data;
            state_d = ISSUE_ENQ;
          end
        end else if (deq_pend_q) begin
          deq_pend_d = 1'b0;
          hold_d     = '0;
          if (len_in == '0) begin
            err_empty_d = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = ISSUE_DEQ;
          end
        end
      end
      ISSUE_ENQ, ISSUE_DEQ: begin
        err_full_d  = 1'b0;
        err_empty_d = 1'b0;
        hold_d      = '0;
        state_d     = HOLD;
      end
      HOLD: begin
        if (hold_q == HW'(HOLD_EFF - 1)) state_d = IDLE;
        else                             hold_d  = hold_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      enq_pend_q  <= 1'b0;
      deq_pend_q  <= 1'b0;
      data_q      <= '0;
      err_full_q  <= 1'b0;
      err_empty_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      enq_pend_q  <= enq_pend_d;
      deq_pend_q  <= deq_pend_d;
      data_q      <= data_d;
      err_full_q  <= err_full_d;
      err_empty_q <= err_empty_d;
    end
  end

  // Strobes decode straight from the state register so they are exactly one
  // cycle wide and can never coincide.
  assign enqueue_out = (state_q == ISSUE_ENQ);
  assign dequeue_out = (state_q == ISSUE_DEQ);
  assign busy        = (state_q != IDLE);
  assign data_out    = data_q;
  assign err_full    = err_full_q;
  assign err_empty   = err_empty_q;
endmodule

// File: tb/tb_fila_cmd.sv
// Directed bench for fila_cmd with DEBOUNCE_CYCLES=4, HOLDOFF=3.
module tb_fila_cmd;
  logic       clk_10KHz = 1'b0;
  logic       reset, btn_enq, btn_deq;
  logic [7:0] sw_data, len_in, data_out;
  logic       enqueue_out, dequeue_out, busy, err_full, err_empty;

  int n_chk  = 0;
  int n_fail = 0;

  fila_cmd #(.DATA_W(8), .DEPTH(8), .DEBOUNCE_CYCLES(4), .HOLDOFF(3)) dut (
    .clk_10KHz(clk_10KHz), .reset(reset), .btn_enq(btn_enq), .btn_deq(btn_deq),
    .sw_data(sw_data), .len_in(len_in), .data_out(data_out),
    .enqueue_out(enqueue_out), .dequeue_out(dequeue_out), .busy(busy),
    .err_full(err_full), .err_empty(err_empty)
  );

  always #5 clk_10KHz = ~clk_10KHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_10KHz);
  endtask

  int enq_cnt, deq_cnt, enq_at, deq_at, overlap, adjacent;
  logic prev_strobe;

  initial begin
    reset = 1'b1; btn_enq = 1'b1; btn_deq = 1'b1; sw_data = 8'h00; len_in = 8'h00;
    wait_n(2);
    chk("rst_data", data_out, 8'h00);
    chk("rst_enq", enqueue_out, 1'b0);
    chk("rst_deq", dequeue_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_efull", err_full, 1'b0);
    chk("rst_eempty", err_empty, 1'b0);
    reset = 1'b0; btn_enq = 1'b0; btn_deq = 1'b0;
    enq_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_10KHz);
      if (enqueue_out || dequeue_out || busy) enq_cnt++;
    end
    chk("rst_no_strobe", enq_cnt, 0);

    // Clean enqueue
    sw_data = 8'hA5; len_in = 8'd0; btn_enq = 1'b1;
    wait_n(7); chk("enq_early", enqueue_out, 1'b0);
    wait_n(1); chk("enq_pulse", enqueue_out, 1'b1);
    chk("enq_data", data_out, 8'hA5);
    chk("enq_busy", busy, 1'b1);
    sw_data = 8'h3C;
    wait_n(1); chk("enq_one_cycle", enqueue_out, 1'b0);
    chk("hold1_busy", busy, 1'b1);
    wait_n(2); chk("hold3_busy", busy, 1'b1);
    wait_n(1); chk("hold_done", busy, 1'b0);
    chk("data_held", data_out, 8'hA5);
    btn_enq = 1'b0; wait_n(12);

    // Full guard, then a dequeue clears err_full
    len_in = 8'd8; btn_enq = 1'b1;
    wait_n(8); chk("full_no_enq", enqueue_out, 1'b0);
    chk("full_err", err_full, 1'b1);
    chk("full_busy", busy, 1'b1);
    wait_n(3); chk("full_idle", busy, 1'b0);
    chk("full_data_kept", data_out, 8'hA5);
    btn_enq = 1'b0; wait_n(12);
    btn_deq = 1'b1;
    wait_n(8); chk("deq_pulse", dequeue_out, 1'b1);
    chk("deq_err_still", err_full, 1'b1);
    wait_n(1); chk("deq_one_cycle", dequeue_out, 1'b0);
    chk("deq_clr_full", err_full, 1'b0);
    btn_deq = 1'b0; wait_n(12);

    // Empty guard
    len_in = 8'd0; btn_deq = 1'b1;
    wait_n(8); chk("empty_no_deq", dequeue_out, 1'b0);
    chk("empty_err", err_empty, 1'b1);
    chk("empty_busy", busy, 1'b1);
    wait_n(2); chk("empty_busy3", busy, 1'b1);
    wait_n(1); chk("empty_idle", busy, 1'b0);
    btn_deq = 1'b0; wait_n(12);

    // Simultaneous press: enqueue first, dequeue 5 cycles later
    len_in = 8'd3; sw_data = 8'h77; btn_enq = 1'b1; btn_deq = 1'b1;
    enq_cnt = 0; deq_cnt = 0; enq_at = 0; deq_at = 0; overlap = 0; adjacent = 0;
    prev_strobe = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk_10KHz);
      if (enqueue_out) begin enq_cnt++; enq_at = c; end
      if (dequeue_out) begin deq_cnt++; deq_at = c; end
      if (enqueue_out && dequeue_out) overlap++;
      if (prev_strobe && (enqueue_out || dequeue_out)) adjacent++;
      prev_strobe = enqueue_out | dequeue_out;
    end
    chk("sim_enq_cnt", enq_cnt, 1);
    chk("sim_deq_cnt", deq_cnt, 1);
    chk("sim_enq_at", enq_at, 8);
    chk("sim_deq_at", deq_at, 13);
    chk("sim_overlap", overlap, 0);
    chk("sim_adjacent", adjacent, 0);
    chk("sim_data", data_out, 8'h77);
    chk("sim_eempty_clr", err_empty, 1'b0);
    btn_enq = 1'b0; btn_deq = 1'b0; wait_n(12);

    // Bounce rejection
    len_in = 8'd0; sw_data = 8'h11; enq_cnt = 0;
    for (int b = 0; b < 5; b++) begin
      btn_enq = 1'b1;
      for (int c = 0; c < 3; c++) begin @(negedge clk_10KHz); if (enqueue_out || busy) enq_cnt++; end
      btn_enq = 1'b0;
      for (int c = 0; c < 2; c++) begin @(negedge clk_10KHz); if (enqueue_out || busy) enq_cnt++; end
    end
    chk("bounce_quiet", enq_cnt, 0);
    btn_enq = 1'b1; enq_at = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_10KHz);
      if (enqueue_out) begin enq_cnt++; enq_at = c; end
    end
    chk("bounce_one", enq_cnt, 1);
    chk("bounce_at", enq_at, 8);
    chk("bounce_data", data_out, 8'h11);
    btn_enq = 1'b0; wait_n(12);

    // Reset in the middle of an issued command
    sw_data = 8'h99; btn_enq = 1'b1;
    wait_n(8); chk("mid_pulse", enqueue_out, 1'b1);
    reset = 1'b1;
    wait_n(1); chk("mid_enq_clr", enqueue_out, 1'b0);
    chk("mid_busy_clr", busy, 1'b0);
    chk("mid_data_clr", data_out, 8'h00);
    reset = 1'b0; btn_enq = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
